// File: rtl/g76_pkg.sv
// Shared widths, the pixel write record and the drain-state encoding for the pixel write queue.
// Pure type definitions: no latency and no backpressure.
package g76_pkg;

    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int COLOR_W = 8;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pixel_write_t;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RELEASE
    } queue_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Generic circular-buffer FIFO of pixel writes; the head entry is readable combinationally.
// Write-to-read latency is one edge. A push into a full FIFO is taken only when a pop lands on the same edge.
module pixel_fifo
    import g76_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  pixel_write_t       pushData,
    input  logic               pop,
    output pixel_write_t       popData,
    output logic               full,
    output logic               empty,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    pixel_write_t     mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // When full, wrPtr equals rdPtr: the head is read out before this edge overwrites it.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (doPop && !doPush) begin
                count <= count - 1'b1;
            end
        end
    end

    assign full    = (count == COUNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign popData = mem[rdPtr];

endmodule

// File: rtl/pixel_write_queue.sv
// Queues MCU pixel writes and replays them over a four-phase request/complete handshake.
// Strobe into an idle empty queue raises the request one edge later; writes to a full queue are dropped.
// PIXEL_QUEUE_DROP_COUNT_EN adds a saturating dropped-write counter.
module pixel_write_queue
    import g76_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int COUNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [X_W-1:0]     inXCoord,
    input  logic [Y_W-1:0]     inYCoord,
    input  logic [COLOR_W-1:0] inData,
    input  logic               inWriteStrobe,
    output logic [X_W-1:0]     memoryXCoord,
    output logic [Y_W-1:0]     memoryYCoord,
    output logic [COLOR_W-1:0] memoryWriteData,
    output logic               memoryWriteRequest,
    input  logic               memoryWriteComplete,
    output logic               queueEmpty,
    output logic               queueFull,
    output logic [COUNT_W-1:0] queueCount,
    output logic               overflow,
    input  logic               overflowClear,
    output logic [15:0]        droppedCount
);

    queue_state_t state;
    pixel_write_t inEntry;
    pixel_write_t headEntry;
    logic         popNow;
    logic         dropNow;

    assign inEntry = '{x: inXCoord, y: inYCoord, color: inData};
    assign popNow  = (state == IDLE) && !queueEmpty;
    assign dropNow = inWriteStrobe && queueFull && !popNow;

    pixel_fifo #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (inWriteStrobe),
        .pushData (inEntry),
        .pop      (popNow),
        .popData  (headEntry),
        .full     (queueFull),
        .empty    (queueEmpty),
        .count    (queueCount)
    );

    // Outputs load only on the IDLE pop, so they stay stable for the whole handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            memoryWriteRequest <= 1'b0;
            memoryXCoord       <= '0;
            memoryYCoord       <= '0;
            memoryWriteData    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (popNow) begin
                        memoryXCoord       <= headEntry.x;
                        memoryYCoord       <= headEntry.y;
                        memoryWriteData    <= headEntry.color;
                        memoryWriteRequest <= 1'b1;
                        state              <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (memoryWriteComplete) begin
                        memoryWriteRequest <= 1'b0;
                        state              <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!memoryWriteComplete) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    memoryWriteRequest <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (dropNow) begin
            overflow <= 1'b1;
        end else if (overflowClear) begin
            overflow <= 1'b0;
        end
    end

`ifdef PIXEL_QUEUE_DROP_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            droppedCount <= '0;
        end else if (dropNow) begin
            if (droppedCount != 16'hFFFF) begin
                droppedCount <= droppedCount + 1'b1;
            end
        end else if (overflowClear) begin
            droppedCount <= '0;
        end
    end
`else
    assign droppedCount = '0;
`endif

endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed and randomized bench for pixel_write_queue (DEPTH=4) against a queue-level reference model.
module tb_pixel_write_queue;
    import g76_pkg::*;

    localparam int DEPTH   = 4;
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    logic               clock;
    logic               reset;
    logic [X_W-1:0]     inXCoord;
    logic [Y_W-1:0]     inYCoord;
    logic [COLOR_W-1:0] inData;
    logic               inWriteStrobe;
    logic [X_W-1:0]     memoryXCoord;
    logic [Y_W-1:0]     memoryYCoord;
    logic [COLOR_W-1:0] memoryWriteData;
    logic               memoryWriteRequest;
    logic               memoryWriteComplete;
    logic               queueEmpty;
    logic               queueFull;
    logic [COUNT_W-1:0] queueCount;
    logic               overflow;
    logic               overflowClear;
    logic [15:0]        droppedCount;

    pixel_write_queue #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .inXCoord            (inXCoord),
        .inYCoord            (inYCoord),
        .inData              (inData),
        .inWriteStrobe       (inWriteStrobe),
        .memoryXCoord        (memoryXCoord),
        .memoryYCoord        (memoryYCoord),
        .memoryWriteData     (memoryWriteData),
        .memoryWriteRequest  (memoryWriteRequest),
        .memoryWriteComplete (memoryWriteComplete),
        .queueEmpty          (queueEmpty),
        .queueFull           (queueFull),
        .queueCount          (queueCount),
        .overflow            (overflow),
        .overflowClear       (overflowClear),
        .droppedCount        (droppedCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: stored writes, the write on the memory bus, and the handshake phase
    // seen from the memory manager (0 = nothing outstanding, 1 = request up, 2 = waiting for complete low).
    pixel_write_t mq[$];
    pixel_write_t mOut;
    int           mPhase;
    bit           mOverflow;
    int           mDropped;
    int           mDelivered;
    int           mPeak;
    int           ackWait;
    int           holdWait;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int expDropped();
`ifdef PIXEL_QUEUE_DROP_COUNT_EN
        return mDropped;
`else
        return 0;
`endif
    endfunction

    task automatic modelReset();
        mq.delete();
        mOut      = '0;
        mPhase    = 0;
        mOverflow = 0;
        mDropped  = 0;
    endtask

    task automatic checkAll(string tag);
        check({tag, ".req"},   memoryWriteRequest, mPhase == 1);
        check({tag, ".x"},     memoryXCoord,       mOut.x);
        check({tag, ".y"},     memoryYCoord,       mOut.y);
        check({tag, ".data"},  memoryWriteData,    mOut.color);
        check({tag, ".count"}, queueCount,         mq.size());
        check({tag, ".empty"}, queueEmpty,         mq.size() == 0);
        check({tag, ".full"},  queueFull,          mq.size() == DEPTH);
        check({tag, ".ovf"},   overflow,           mOverflow);
        check({tag, ".drop"},  droppedCount,       expDropped());
    endtask

    // Apply the current inputs at the next rising edge in the model, then compare 1 ns later.
    task automatic step(string tag);
        bit           popNow;
        bit           dropNow;
        pixel_write_t w;
        popNow  = (mPhase == 0) && (mq.size() != 0);
        dropNow = 0;
        if (popNow) begin
            mOut = mq.pop_front();
            mDelivered++;
        end
        if (inWriteStrobe) begin
            w.x = inXCoord; w.y = inYCoord; w.color = inData;
            if (mq.size() < DEPTH) mq.push_back(w);
            else dropNow = 1;
        end
        if (dropNow) begin
            mOverflow = 1;
            if (mDropped < 65535) mDropped++;
        end else if (overflowClear) begin
            mOverflow = 0;
            mDropped  = 0;
        end
        case (mPhase)
            0:       if (popNow) mPhase = 1;
            1:       if (memoryWriteComplete) mPhase = 2;
            default: if (!memoryWriteComplete) mPhase = 0;
        endcase
        @(posedge clock);
        #1;
        if (mq.size() > mPeak) mPeak = mq.size();
        checkAll(tag);
    endtask

    task automatic setWrite(int x, int y, int d);
        inWriteStrobe = 1'b1;
        inXCoord      = X_W'(x);
        inYCoord      = Y_W'(y);
        inData        = COLOR_W'(d);
    endtask

    // Memory manager: acknowledge ackDly cycles into a request, hold complete holdDly extra cycles.
    task automatic mgr(int ackDly, int holdDly);
        case (mPhase)
            1: if (ackWait == 0) memoryWriteComplete = 1'b1; else ackWait--;
            2: if (holdWait == 0) memoryWriteComplete = 1'b0; else holdWait--;
            default: begin
                memoryWriteComplete = 1'b0;
                ackWait  = ackDly;
                holdWait = holdDly;
            end
        endcase
    endtask

    task automatic drain(string tag, int ackDly, int holdDly);
        int n;
        n = 0;
        inWriteStrobe = 1'b0;
        while ((mq.size() != 0 || mPhase != 0) && n < 300) begin
            mgr(ackDly, holdDly);
            step(tag);
            n++;
        end
        check({tag, ".timeout"}, n >= 300, 0);
        memoryWriteComplete = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1;
        inWriteStrobe = 1'b0; inXCoord = '0; inYCoord = '0; inData = '0;
        memoryWriteComplete = 1'b0; overflowClear = 1'b0;
        mDelivered = 0; mPeak = 0; ackWait = 0; holdWait = 0;
        modelReset();
        #3;
        checkAll("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 1: single write, latency and handshake phases
        setWrite(257, 2, 3);
        step("t1.push");
        inWriteStrobe = 1'b0;
        step("t1.lat");
        check("t1.reqHigh", memoryWriteRequest, 1);
        check("t1.xVal", memoryXCoord, 257);
        check("t1.yVal", memoryYCoord, 2);
        check("t1.dVal", memoryWriteData, 3);
        memoryWriteComplete = 1'b1;
        step("t1.ack1");
        check("t1.reqLow", memoryWriteRequest, 0);
        step("t1.ack2");
        memoryWriteComplete = 1'b0;
        step("t1.rel");
        step("t1.idle");

        // 2: burst of five with a slow manager
        base = mDelivered; mPeak = 0;
        for (int i = 0; i < 5; i++) begin
            setWrite(10 + i, 20 + i, 30 + i);
            mgr(3, 0);
            step("t2.burst");
        end
        drain("t2.drain", 3, 0);
        check("t2.peak", mPeak, 4);
        check("t2.delivered", mDelivered - base, 5);
        check("t2.endCount", queueCount, 0);

        // 3: overflow with complete held low
        memoryWriteComplete = 1'b0;
        for (int i = 0; i < 6; i++) begin
            setWrite(100 + i, 50 + i, 200 + i);
            step("t3.fill");
        end
        inWriteStrobe = 1'b0;
        check("t3.full", queueFull, 1);
        check("t3.ovf", overflow, 1);
        check("t3.dropCnt", droppedCount, expDropped());
        overflowClear = 1'b1;
        step("t3.clear");
        overflowClear = 1'b0;
        check("t3.ovfCleared", overflow, 0);

        // 4: strobe on the same edge as the IDLE pop while full
        memoryWriteComplete = 1'b1;
        step("t4.ack");
        memoryWriteComplete = 1'b0;
        step("t4.rel");
        setWrite(77, 88, 99);
        step("t4.pushPop");
        inWriteStrobe = 1'b0;
        check("t4.count", queueCount, 4);
        check("t4.ovf", overflow, 0);
        check("t4.req", memoryWriteRequest, 1);
        drain("t4.drain", 0, 0);

        // 5: ten writes across several pointer wraps
        base = mDelivered;
        for (int i = 0; i < 10; i++) begin
            setWrite(300 + i, 5 * i, 255 - i);
            mgr(0, 0);
            step("t5.push");
            inWriteStrobe = 1'b0;
            for (int j = 0; j < 3; j++) begin
                mgr(0, 0);
                step("t5.gap");
            end
        end
        drain("t5.drain", 0, 0);
        check("t5.delivered", mDelivered - base, 10);
        check("t5.ovf", overflow, 0);

        // 6: reset in the middle of a request
        setWrite(1, 1, 1);
        step("t6.a");
        setWrite(2, 2, 2);
        step("t6.b");
        setWrite(3, 3, 3);
        step("t6.c");
        inWriteStrobe = 1'b0;
        reset = 1'b1;
        modelReset();
        #1;
        checkAll("t6.async");
        @(posedge clock);
        #1;
        reset = 1'b0;
        setWrite(5, 6, 7);
        step("t6.post");
        inWriteStrobe = 1'b0;
        step("t6.postLat");
        check("t6.postReq", memoryWriteRequest, 1);
        check("t6.postX", memoryXCoord, 5);
        drain("t6.drain", 1, 1);

        // Randomized traffic, overflow clears and stray completes while idle
        for (int i = 0; i < 1500; i++) begin
            inWriteStrobe = ($urandom_range(0, 99) < 35);
            inXCoord      = X_W'($urandom);
            inYCoord      = Y_W'($urandom);
            inData        = COLOR_W'($urandom);
            overflowClear = ($urandom_range(0, 99) < 3);
            mgr($urandom_range(0, 4), $urandom_range(0, 2));
            if (mPhase == 0 && mq.size() == 0 && !inWriteStrobe && $urandom_range(0, 9) == 0)
                memoryWriteComplete = 1'b1;
            step("rnd");
        end
        overflowClear = 1'b0;
        drain("rnd.drain", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
